// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1-style TAP state machine and scan-path strobe decode
//
// Purpose:
//   Walks the 16-state TAP graph on tms and decodes the current state into the
//   shift/capture/update strobes of the IR scan path, the scan block and the
//   bypass register. It also muxes their serial outputs onto tdo. The 4-bit
//   state register is the only storage; every output is a combinational decode.
//
// Optional feature macro: TAP_INSTR_DECODE_EN
//   defined   : instruction selects the DR (00/01 scan block, 10/11 bypass).
//   undefined : scan block is always the selected DR; byp_* tied to 0 and
//               instruction / byp_tdo are ignored.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high, forces Test-Logic-Reset
//   tms          in   test mode select
//   instruction  in   IR shadow register contents (IR_WIDTH bits)
//   ir_tdo       in   serial out of IR scan path
//   scan_tdo     in   serial out of scan block
//   byp_tdo      in   serial out of bypass register
//   ir_*         out  IR scan path capture/shift/update
//   scan_*       out  scan block capture/shift/update
//   byp_*        out  bypass register capture/shift/update
//   tdo          out  serial test data out
//   tdo_en       out  high while tdo carries shift data
//   tlr          out  high in Test-Logic-Reset
//   tap_state    out  current state encoding

module tap_controller #(
    parameter int IR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tms,
    input  logic [IR_WIDTH-1:0] instruction,
    input  logic                ir_tdo,
    input  logic                scan_tdo,
    input  logic                byp_tdo,
    output logic                ir_shift,
    output logic                ir_capture,
    output logic                ir_update,
    output logic                scan_shift,
    output logic                scan_capture,
    output logic                scan_update,
    output logic                byp_shift,
    output logic                byp_capture,
    output logic                byp_update,
    output logic                tdo,
    output logic                tdo_en,
    output logic                tlr,
    output logic [3:0]          tap_state
);

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SH_DR    = 4'h2,
        ST_EX1_DR   = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EX2_DR   = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SH_IR    = 4'hA,
        ST_EX1_IR   = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EX2_IR   = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_t;

    tap_state_t r_state;
    tap_state_t w_next;

    logic w_sel_byp;
    logic w_dr_capture;
    logic w_dr_shift;
    logic w_dr_update;

    // State register: reset wins over tms in every state, including mid-shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_TLR;
        unique case (r_state)
            ST_TLR:      w_next = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      w_next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   w_next = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   w_next = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    w_next = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   w_next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: w_next = tms ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   w_next = tms ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   w_next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   w_next = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   w_next = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    w_next = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   w_next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: w_next = tms ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   w_next = tms ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   w_next = tms ? ST_SEL_DR   : ST_RTI;
            default:     w_next = ST_TLR;
        endcase
    end

`ifdef TAP_INSTR_DECODE_EN
    // Upper half of the instruction space selects bypass; TLR forces bypass
    // so a freshly reset chain is one bit long per device.
    assign w_sel_byp = (r_state == ST_TLR) ||
                       (instruction >= IR_WIDTH'(2));
`else
    // Scan block is the only DR; these inputs have no effect in this build.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{instruction, byp_tdo};
    assign w_sel_byp       = 1'b0;
`endif

    assign w_dr_capture = (r_state == ST_CAP_DR);
    assign w_dr_shift   = (r_state == ST_SH_DR);
    assign w_dr_update  = (r_state == ST_UPD_DR);

    always_comb begin
        ir_capture   = 1'b0;
        ir_shift     = 1'b0;
        ir_update    = 1'b0;
        scan_capture = 1'b0;
        scan_shift   = 1'b0;
        scan_update  = 1'b0;
        byp_capture  = 1'b0;
        byp_shift    = 1'b0;
        byp_update   = 1'b0;
        tdo          = 1'b0;
        tdo_en       = 1'b0;

        ir_capture = (r_state == ST_CAP_IR);
        ir_shift   = (r_state == ST_SH_IR);
        ir_update  = (r_state == ST_UPD_IR);

        if (w_sel_byp) begin
            byp_capture = w_dr_capture;
            byp_shift   = w_dr_shift;
            byp_update  = w_dr_update;
        end else begin
            scan_capture = w_dr_capture;
            scan_shift   = w_dr_shift;
            scan_update  = w_dr_update;
        end

        if (r_state == ST_SH_IR) begin
            tdo    = ir_tdo;
            tdo_en = 1'b1;
        end else if (r_state == ST_SH_DR) begin
`ifdef TAP_INSTR_DECODE_EN
            tdo    = w_sel_byp ? byp_tdo : scan_tdo;
`else
            tdo    = scan_tdo;
`endif
            tdo_en = 1'b1;
        end
    end

    assign tlr       = (r_state == ST_TLR);
    assign tap_state = r_state;

endmodule
